// File: rtl/st_commit_queue_pkg.sv
// Shared types for the in-order store commit queue: entry layout, AGU/CDB
// packets, the completion broadcast and the write FSM states.
package st_commit_queue_pkg;

  localparam int ST_QUEUE_DEPTH = 8;
  localparam int ST_TAG_W       = $clog2(ST_QUEUE_DEPTH) + 1;
  localparam int BMASK_W        = 4;
  localparam int BR_BIT_W       = $clog2(BMASK_W);

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mem_pkt_t;

  typedef struct packed {
    logic                broadcast;
    logic                br_mispred;
    logic [BR_BIT_W-1:0] br_bit;
  } cdb_pkt_t;

  typedef struct packed {
    logic                st_tag_broadcast;
    logic [ST_TAG_W-1:0] store_tag;
  } st_tag_pkt_t;

  typedef struct packed {
    logic               valid;
    logic               addr_valid;
    logic               committed;
    logic [BMASK_W-1:0] bmask;
    logic [31:0]        addr;
    logic [31:0]        wdata;
    logic [3:0]         wmask;
  } st_entry_t;

  typedef enum logic {ST_IDLE, ST_WRITE} st_fsm_t;

endpackage

// File: rtl/st_commit_queue.sv
// In-order store queue: allocates tags at dispatch, captures AGU results,
// writes committed stores to memory and broadcasts each retired tag.
module st_commit_queue
  import st_commit_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH = ST_QUEUE_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                st_alloc_valid,
  input  logic [BMASK_W-1:0]  st_alloc_bmask,
  output logic                st_alloc_ready,
  output logic [ST_TAG_W-1:0] st_alloc_tag,
  output logic [ST_TAG_W-1:0] st_youngest_tag,
  output logic                st_empty,
  input  logic                st_addr_wen,
  input  logic [ST_TAG_W-1:0] st_addr_tag,
  input  mem_pkt_t            st_addr_pkt,
  input  logic                rob_commit_st,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_wmask,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_resp,
  input  cdb_pkt_t            cdb_pkt2,
  output st_tag_pkt_t         st_tag_pkt
);

  localparam int IDX_W = $clog2(QUEUE_DEPTH);
  localparam int TAG_W = IDX_W + 1;

  st_entry_t        r_entries [QUEUE_DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_commit;
  logic [TAG_W-1:0] r_tail;
  st_fsm_t          r_state;
  logic [31:0]      r_dmem_addr;
  logic [31:0]      r_dmem_wdata;
  logic [3:0]       r_dmem_wmask;
  st_tag_pkt_t      r_tag_pkt;

  logic [IDX_W-1:0]       w_head_idx;
  logic [IDX_W-1:0]       w_commit_idx;
  logic [IDX_W-1:0]       w_tail_idx;
  logic [IDX_W-1:0]       w_agu_idx;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_mispred;
  logic                   w_correct;
  logic                   w_alloc;
  logic                   w_commit;
  logic                   w_retire;
  logic [BMASK_W-1:0]     w_alloc_bmask;
  logic [QUEUE_DEPTH-1:0] w_victim;
  logic [TAG_W-1:0]       w_live;
  logic [TAG_W-1:0]       w_occupancy;
  logic [TAG_W-1:0]       w_agu_offset;
  logic [TAG_W-1:0]       w_slot;
  logic [TAG_W-1:0]       w_rollback_tail;
  logic                   w_agu_ok;
  st_entry_t              w_head_entry;
  logic                   w_head_committed;
  logic                   w_head_addr_valid;
  logic                   w_issue;
  mem_pkt_t               w_head_pkt;

  assign w_head_idx   = r_head[IDX_W-1:0];
  assign w_commit_idx = r_commit[IDX_W-1:0];
  assign w_tail_idx   = r_tail[IDX_W-1:0];
  assign w_agu_idx    = st_addr_tag[IDX_W-1:0];

  assign w_empty   = (r_head == r_tail);
  assign w_full    = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_mispred = cdb_pkt2.broadcast & cdb_pkt2.br_mispred;
  assign w_correct = cdb_pkt2.broadcast & ~cdb_pkt2.br_mispred;
  assign w_alloc   = st_alloc_valid & st_alloc_ready;
  assign w_commit  = rob_commit_st & (r_commit != r_tail);
  assign w_retire  = (r_state == ST_WRITE) & dmem_resp;

  always_comb begin
    w_alloc_bmask = st_alloc_bmask;
    if (w_correct) w_alloc_bmask[cdb_pkt2.br_bit] = 1'b0;
  end

  always_comb begin
    w_victim = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_victim[i] = w_mispred & r_entries[i].valid & ~r_entries[i].committed &
                    r_entries[i].bmask[cdb_pkt2.br_bit];
    end
  end

  // Victims are contiguous at the young end, so the oldest one is the new tail.
  assign w_live = r_tail - r_commit;
  always_comb begin
    w_rollback_tail = r_tail;
    w_slot          = '0;
    for (int k = QUEUE_DEPTH - 1; k >= 0; k--) begin
      w_slot = r_commit + TAG_W'(k);
      if ((TAG_W'(k) < w_live) && w_victim[w_slot[IDX_W-1:0]]) w_rollback_tail = w_slot;
    end
  end

  assign w_occupancy  = r_tail - r_head;
  assign w_agu_offset = st_addr_tag - r_head;
  assign w_agu_ok     = st_addr_wen & (w_agu_offset < w_occupancy) &
                        r_entries[w_agu_idx].valid & ~w_victim[w_agu_idx];

  // Same-cycle commit and AGU results are forwarded so the write issues next cycle.
  assign w_head_entry      = r_entries[w_head_idx];
  assign w_head_committed  = w_head_entry.committed | (w_commit & (r_commit == r_head));
  assign w_head_addr_valid = w_head_entry.addr_valid | (w_agu_ok & (w_agu_idx == w_head_idx));
  assign w_issue           = (r_state == ST_IDLE) & ~w_empty & w_head_entry.valid &
                             w_head_committed & w_head_addr_valid;

  always_comb begin
    w_head_pkt = st_addr_pkt;
    if (w_head_entry.addr_valid) begin
      w_head_pkt.addr  = w_head_entry.addr;
      w_head_pkt.wdata = w_head_entry.wdata;
      w_head_pkt.wmask = w_head_entry.wmask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) r_entries[i] <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (w_victim[i]) r_entries[i].valid <= 1'b0;
        if (w_correct)   r_entries[i].bmask[cdb_pkt2.br_bit] <= 1'b0;
      end
      if (w_commit) r_entries[w_commit_idx].committed <= 1'b1;
      if (w_agu_ok) begin
        r_entries[w_agu_idx].addr       <= st_addr_pkt.addr;
        r_entries[w_agu_idx].wdata      <= st_addr_pkt.wdata;
        r_entries[w_agu_idx].wmask      <= st_addr_pkt.wmask;
        r_entries[w_agu_idx].addr_valid <= 1'b1;
      end
      if (w_alloc) begin
        r_entries[w_tail_idx] <= '{valid: 1'b1, addr_valid: 1'b0, committed: 1'b0,
                                   bmask: w_alloc_bmask, addr: '0, wdata: '0, wmask: '0};
      end
      if (w_retire) r_entries[w_head_idx].valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head   <= '0;
      r_commit <= '0;
      r_tail   <= '0;
    end else begin
      if (w_retire) r_head <= r_head + TAG_W'(1);
      if (w_commit) r_commit <= r_commit + TAG_W'(1);
      if (w_mispred)    r_tail <= w_rollback_tail;
      else if (w_alloc) r_tail <= r_tail + TAG_W'(1);
    end
  end

  // Passing through IDLE after every response limits throughput to one store per two cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_wmask <= '0;
      r_tag_pkt    <= '0;
    end else begin
      r_tag_pkt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_state      <= ST_WRITE;
            r_dmem_addr  <= w_head_pkt.addr & WORD_ALIGN_MASK;
            r_dmem_wdata <= w_head_pkt.wdata;
            r_dmem_wmask <= w_head_pkt.wmask;
          end
        end
        ST_WRITE: begin
          if (dmem_resp) begin
            r_state      <= ST_IDLE;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wmask <= '0;
            r_tag_pkt    <= '{st_tag_broadcast: 1'b1, store_tag: r_head};
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always @(posedge clk) begin
    if (rst_n && rob_commit_st) begin
      assert (r_commit != r_tail) else $error("store commit with no uncommitted store");
    end
  end

  assign st_alloc_ready  = ~w_full & ~w_mispred;
  assign st_alloc_tag    = r_tail;
  assign st_youngest_tag = r_tail - TAG_W'(1);
  assign st_empty        = w_empty;
  assign dmem_addr       = r_dmem_addr;
  assign dmem_wdata      = r_dmem_wdata;
  assign dmem_wmask      = r_dmem_wmask;
  assign st_tag_pkt      = r_tag_pkt;

endmodule

// File: tb/tb_st_commit_queue.sv
// Directed bench for st_commit_queue: a queue-level model is compared against
// the DUT every cycle, with literal checks at the key points of each scenario.
module tb_st_commit_queue;
  import st_commit_queue_pkg::*;

  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                st_alloc_valid;
  logic [BMASK_W-1:0]  st_alloc_bmask;
  logic                st_alloc_ready;
  logic [ST_TAG_W-1:0] st_alloc_tag;
  logic [ST_TAG_W-1:0] st_youngest_tag;
  logic                st_empty;
  logic                st_addr_wen;
  logic [ST_TAG_W-1:0] st_addr_tag;
  mem_pkt_t            st_addr_pkt;
  logic                rob_commit_st;
  logic [31:0]         dmem_addr;
  logic [3:0]          dmem_wmask;
  logic [31:0]         dmem_wdata;
  logic                dmem_resp;
  cdb_pkt_t            cdb_pkt2;
  st_tag_pkt_t         st_tag_pkt;

  typedef struct packed {
    logic               alloc;
    logic [BMASK_W-1:0] bmask;
    logic               wen;
    logic [3:0]         atag;
    mem_pkt_t           pkt;
    logic               commit;
    logic               resp;
    cdb_pkt_t           cdb;
  } stim_t;

  typedef struct {
    logic [3:0]  tag;
    logic [3:0]  bmask;
    bit          av;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    bit          committed;
  } mrec_t;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  mrec_t       mq[$];
  logic [3:0]  mNext;
  bit          mBusy;
  logic [3:0]  mBusyTag;
  logic [31:0] mAddr;
  logic [31:0] mData;
  logic [3:0]  mMask;
  bit          mBc;
  logic [3:0]  mBcTag;

  always #5 clk = ~clk;

  st_commit_queue #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_alloc_valid(st_alloc_valid), .st_alloc_bmask(st_alloc_bmask),
    .st_alloc_ready(st_alloc_ready), .st_alloc_tag(st_alloc_tag),
    .st_youngest_tag(st_youngest_tag), .st_empty(st_empty),
    .st_addr_wen(st_addr_wen), .st_addr_tag(st_addr_tag), .st_addr_pkt(st_addr_pkt),
    .rob_commit_st(rob_commit_st),
    .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_resp(dmem_resp), .cdb_pkt2(cdb_pkt2), .st_tag_pkt(st_tag_pkt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive(input stim_t s);
    st_alloc_valid = s.alloc;
    st_alloc_bmask = s.bmask;
    st_addr_wen    = s.wen;
    st_addr_tag    = s.atag;
    st_addr_pkt    = s.pkt;
    rob_commit_st  = s.commit;
    dmem_resp      = s.resp;
    cdb_pkt2       = s.cdb;
  endtask

  task automatic applyStimulus(input stim_t s);
    drive(s);
    @(posedge clk);
    #1;
    drive('0);
  endtask

  task automatic doReset();
    drive('0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic mem_pkt_t mkPkt(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    mem_pkt_t p;
    p.addr = a; p.wdata = d; p.wmask = m;
    return p;
  endfunction

  // Reference model: a list of live stores, oldest first, plus the single write in flight.
  always @(posedge clk or negedge rst_n) begin
    bit    mis, cor, rdy;
    bit    vict [DEPTH];
    mrec_t r;
    if (!rst_n) begin
      mq.delete();
      mNext = '0; mBusy = 0; mBusyTag = '0; mAddr = '0; mData = '0; mMask = '0;
      mBc = 0; mBcTag = '0;
    end else begin
      mis = cdb_pkt2.broadcast && cdb_pkt2.br_mispred;
      cor = cdb_pkt2.broadcast && !cdb_pkt2.br_mispred;
      rdy = (mq.size() < DEPTH) && !mis;
      mBc    = mBusy && dmem_resp;
      mBcTag = mBusyTag;
      for (int i = 0; i < DEPTH; i++) vict[i] = 0;
      for (int i = 0; i < mq.size(); i++)
        vict[i] = mis && !mq[i].committed && mq[i].bmask[cdb_pkt2.br_bit];
      if (rob_commit_st) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].committed) begin
            r = mq[i]; r.committed = 1; mq[i] = r;
            break;
          end
        end
      end
      if (st_addr_wen) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (mq[i].tag == st_addr_tag && !vict[i]) begin
            r = mq[i];
            r.av = 1; r.addr = st_addr_pkt.addr; r.wdata = st_addr_pkt.wdata; r.wmask = st_addr_pkt.wmask;
            mq[i] = r;
          end
        end
      end
      if (mis) begin
        while (mq.size() > 0 && vict[mq.size() - 1]) begin
          mNext = mq[mq.size() - 1].tag;
          void'(mq.pop_back());
        end
      end
      if (cor) begin
        for (int i = 0; i < mq.size(); i++) begin
          r = mq[i]; r.bmask[cdb_pkt2.br_bit] = 1'b0; mq[i] = r;
        end
      end
      if (mBusy) begin
        if (dmem_resp) begin
          void'(mq.pop_front());
          mBusy = 0;
        end
      end else if (mq.size() > 0 && mq[0].committed && mq[0].av) begin
        mBusy = 1; mBusyTag = mq[0].tag;
        mAddr = mq[0].addr; mData = mq[0].wdata; mMask = mq[0].wmask;
      end
      if (st_alloc_valid && rdy) begin
        r.tag = mNext; r.bmask = st_alloc_bmask; r.av = 0; r.committed = 0;
        r.addr = '0; r.wdata = '0; r.wmask = '0;
        if (cor) r.bmask[cdb_pkt2.br_bit] = 1'b0;
        mq.push_back(r);
        mNext = mNext + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cmp_ready", st_alloc_ready,
                  ((mq.size() < DEPTH) && !(cdb_pkt2.broadcast && cdb_pkt2.br_mispred)) ? 1 : 0);
      checkOutput("cmp_alloc_tag", st_alloc_tag, mNext);
      checkOutput("cmp_youngest", st_youngest_tag, 4'(mNext - 4'd1));
      checkOutput("cmp_empty", st_empty, (mq.size() == 0) ? 1 : 0);
      checkOutput("cmp_dmem_addr", dmem_addr, mBusy ? (mAddr & 32'hFFFF_FFFC) : 32'h0);
      checkOutput("cmp_dmem_wdata", dmem_wdata, mBusy ? mData : 32'h0);
      checkOutput("cmp_dmem_wmask", dmem_wmask, mBusy ? mMask : 4'h0);
      checkOutput("cmp_tag_pkt", st_tag_pkt, mBc ? {1'b1, mBcTag} : 5'h0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t    s;
    mem_pkt_t t1Pkts [3];
    t1Pkts[0] = mkPkt(32'h0000_1003, 32'hA0A0_0000, 4'b0001);
    t1Pkts[1] = mkPkt(32'h0000_1004, 32'hA0A0_0001, 4'b0011);
    t1Pkts[2] = mkPkt(32'h0000_1008, 32'hA0A0_0002, 4'b1111);
    rst_n = 1'b0;
    drive('0);

    // Reset values, three in-order stores and their broadcasts.
    doReset();
    checkEn = 1'b1;
    checkOutput("rst_ready", st_alloc_ready, 1);
    checkOutput("rst_empty", st_empty, 1);
    checkOutput("rst_alloc_tag", st_alloc_tag, 0);
    checkOutput("rst_youngest", st_youngest_tag, 4'hF);
    checkOutput("rst_wmask", dmem_wmask, 0);
    checkOutput("rst_tag_pkt", st_tag_pkt, 0);
    for (int i = 0; i < 3; i++) begin
      s = '0; s.alloc = 1;
      checkOutput("t1_alloc_tag", st_alloc_tag, i);
      applyStimulus(s);
    end
    checkOutput("t1_youngest", st_youngest_tag, 2);
    checkOutput("t1_empty", st_empty, 0);
    for (int i = 0; i < 3; i++) begin
      s = '0; s.wen = 1; s.atag = 4'(i); s.pkt = t1Pkts[i];
      applyStimulus(s);
    end
    s = '0; s.commit = 1; applyStimulus(s);
    checkOutput("t1_w0_addr", dmem_addr, 32'h1000);
    checkOutput("t1_w0_mask", dmem_wmask, 4'b0001);
    s = '0; s.commit = 1; s.resp = 1; applyStimulus(s);
    checkOutput("t1_bc0", st_tag_pkt, 5'h10);
    checkOutput("t1_idle_mask", dmem_wmask, 0);
    applyStimulus('0);
    checkOutput("t1_bc0_once", st_tag_pkt, 0);
    checkOutput("t1_w1_addr", dmem_addr, 32'h1004);
    s = '0; s.resp = 1; applyStimulus(s);
    checkOutput("t1_bc1", st_tag_pkt, 5'h11);
    s = '0; s.commit = 1; applyStimulus(s);
    checkOutput("t1_w2_addr", dmem_addr, 32'h1008);
    checkOutput("t1_w2_data", dmem_wdata, 32'hA0A0_0002);
    s = '0; s.resp = 1; applyStimulus(s);
    checkOutput("t1_bc2", st_tag_pkt, 5'h12);
    checkOutput("t1_empty_end", st_empty, 1);
    applyStimulus('0);

    // Full queue, retire while full, and wrap to tag 8.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      s = '0; s.alloc = 1; applyStimulus(s);
    end
    checkOutput("t2_full_ready", st_alloc_ready, 0);
    checkOutput("t2_full_tag", st_alloc_tag, 8);
    s = '0; s.alloc = 1; applyStimulus(s);
    checkOutput("t2_reject_tag", st_alloc_tag, 8);
    s = '0; s.wen = 1; s.atag = 0; s.pkt = mkPkt(32'h3000, 32'h11, 4'hF); s.commit = 1;
    applyStimulus(s);
    checkOutput("t2_w_addr", dmem_addr, 32'h3000);
    s = '0; s.resp = 1; s.alloc = 1;
    drive(s);
    #1 checkOutput("t2_retire_ready", st_alloc_ready, 0);
    @(posedge clk); #1 drive('0);
    checkOutput("t2_after_ready", st_alloc_ready, 1);
    checkOutput("t2_next_tag", st_alloc_tag, 8);
    checkOutput("t2_bc", st_tag_pkt, 5'h10);
    s = '0; s.alloc = 1; applyStimulus(s);
    checkOutput("t2_youngest", st_youngest_tag, 8);
    checkOutput("t2_full_again", st_alloc_ready, 0);

    // Mispredict squashes the young stores; blocked alloc and AGU write to a victim.
    doReset();
    for (int i = 0; i < 4; i++) begin
      s = '0; s.alloc = 1; s.bmask = (i >= 2) ? 4'b0010 : 4'b0000; applyStimulus(s);
    end
    s = '0; s.commit = 1; applyStimulus(s);
    checkOutput("t3_no_write", dmem_wmask, 0);
    s = '0; s.cdb = '{broadcast: 1'b1, br_mispred: 1'b1, br_bit: 2'd1};
    s.alloc = 1; s.wen = 1; s.atag = 3; s.pkt = mkPkt(32'h6000, 32'h66, 4'hF);
    drive(s);
    #1 checkOutput("t3_mis_ready", st_alloc_ready, 0);
    @(posedge clk); #1 drive('0);
    checkOutput("t3_tail", st_alloc_tag, 2);
    checkOutput("t3_youngest", st_youngest_tag, 1);
    s = '0; s.wen = 1; s.atag = 0; s.pkt = mkPkt(32'h4000, 32'h40, 4'h3); applyStimulus(s);
    checkOutput("t3_w0_addr", dmem_addr, 32'h4000);
    s = '0; s.resp = 1; applyStimulus(s);
    checkOutput("t3_bc0", st_tag_pkt, 5'h10);
    s = '0; s.wen = 1; s.atag = 1; s.pkt = mkPkt(32'h4004, 32'h41, 4'hF); s.commit = 1;
    applyStimulus(s);
    s = '0; s.resp = 1; applyStimulus(s);
    checkOutput("t3_bc1", st_tag_pkt, 5'h11);
    checkOutput("t3_empty", st_empty, 1);

    // Correct prediction clears the bit on the store being allocated.
    doReset();
    s = '0; s.alloc = 1; s.bmask = 4'b0010;
    s.cdb = '{broadcast: 1'b1, br_mispred: 1'b0, br_bit: 2'd1};
    applyStimulus(s);
    s = '0; s.alloc = 1; s.bmask = 4'b0010; applyStimulus(s);
    s = '0; s.cdb = '{broadcast: 1'b1, br_mispred: 1'b1, br_bit: 2'd1}; applyStimulus(s);
    checkOutput("t4_tail", st_alloc_tag, 1);
    checkOutput("t4_not_empty", st_empty, 0);
    s = '0; s.wen = 1; s.atag = 0; s.pkt = mkPkt(32'h7000, 32'h70, 4'h1); s.commit = 1;
    applyStimulus(s);
    s = '0; s.resp = 1; applyStimulus(s);
    checkOutput("t4_bc0", st_tag_pkt, 5'h10);

    // Write held without response, then a reset in the middle of a write.
    doReset();
    s = '0; s.alloc = 1; applyStimulus(s);
    s = '0; s.wen = 1; s.atag = 0; s.pkt = mkPkt(32'h2002, 32'hDEAD_BEEF, 4'hC); applyStimulus(s);
    s = '0; s.commit = 1; applyStimulus(s);
    for (int i = 0; i < 5; i++) begin
      checkOutput("t5_hold_addr", dmem_addr, 32'h2000);
      checkOutput("t5_hold_data", dmem_wdata, 32'hDEAD_BEEF);
      checkOutput("t5_hold_mask", dmem_wmask, 4'hC);
      checkOutput("t5_hold_nobc", st_tag_pkt, 0);
      applyStimulus('0);
    end
    s = '0; s.resp = 1; applyStimulus(s);
    checkOutput("t5_bc0", st_tag_pkt, 5'h10);
    s = '0; s.alloc = 1; applyStimulus(s);
    s = '0; s.wen = 1; s.atag = 1; s.pkt = mkPkt(32'h2100, 32'h1234_5678, 4'hF); s.commit = 1;
    applyStimulus(s);
    checkOutput("t5_w1_addr", dmem_addr, 32'h2100);
    applyStimulus('0);
    applyStimulus('0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_addr", dmem_addr, 0);
    checkOutput("t5_rst_data", dmem_wdata, 0);
    checkOutput("t5_rst_mask", dmem_wmask, 0);
    checkOutput("t5_rst_ready", st_alloc_ready, 1);
    checkOutput("t5_rst_empty", st_empty, 1);
    checkOutput("t5_rst_tag", st_alloc_tag, 0);
    checkOutput("t5_rst_pkt", st_tag_pkt, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s = '0; s.resp = 1; applyStimulus(s);
      checkOutput("t5_no_bc", st_tag_pkt, 0);
    end

    // Commit ahead of the AGU result: the write waits for the address.
    doReset();
    s = '0; s.alloc = 1; applyStimulus(s);
    s = '0; s.commit = 1; applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t6_wait_mask", dmem_wmask, 0);
      applyStimulus('0);
    end
    s = '0; s.wen = 1; s.atag = 0; s.pkt = mkPkt(32'h5000, 32'h55AA_55AA, 4'h6); applyStimulus(s);
    checkOutput("t6_addr", dmem_addr, 32'h5000);
    checkOutput("t6_mask", dmem_wmask, 4'h6);
    s = '0; s.resp = 1; applyStimulus(s);
    checkOutput("t6_bc0", st_tag_pkt, 5'h10);
    applyStimulus('0);

    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
